ps_threshold_top: RTL and testbench
===================================

Name: ps_threshold_top

Overview:
- Binary-threshold stage between the Sobel operator output FIFO and the memory interface, in the i_sysclk processing domain.
- Reads 12-bit RGB444 pixels from the upstream FIFO and computes a luminance sum.
- Emits 12'hFFF or 12'h000 per pixel (or passes the pixel through when disabled) into its own output FIFO.
- Counts pixels per frame and reports a per-frame white-pixel count.

Parameters:
- DATA_WIDTH, 12, pixel width {R[11:8],G[7:4],B[3:0]}
- FRAME_PIXELS, 307200, pixels per frame (640x480)
- OBUF_DEPTH, 1024, output FIFO depth (power of 2)
- OBUF_AE_THRESH, 16, almostempty asserted when fill <= this
- OBUF_AF_MARGIN, 4, almostfull asserted when fill >= OBUF_DEPTH - this

Ports:
- i_sysclk  in  1  processing clock, 125 MHz
- db_rstn  in  1  reset, asynchronous, active-low
- i_enable  in  1  threshold enable (0 = bypass)
- i_threshold  in  6  luminance threshold, 0..60
- i_flush  in  1  synchronous pipeline flush
- i_data  in  12  upstream FIFO read data, valid 1 cycle after o_rd
- i_almostempty  in  1  upstream FIFO almostempty
- o_rd  out  1  upstream FIFO read strobe
- i_obuf_rd  in  1  output FIFO read strobe
- o_obuf_data  out  12  output FIFO data, valid 1 cycle after i_obuf_rd
- o_obuf_fill  out  log2(OBUF_DEPTH)+1  output FIFO occupancy
- o_obuf_empty  out  1  output FIFO empty
- o_obuf_almostempty  out  1  output FIFO almostempty
- o_eof  out  1  one-cycle pulse when the last pixel of a frame is written to obuf
- o_white_count  out  19  white-pixel count of the last completed frame

Behaviour:
- Reset (db_rstn low, asynchronous): o_rd=0, o_obuf_data=0, fill=0, o_obuf_empty=1, o_obuf_almostempty=1, o_eof=0, o_white_count=0. Pixel counter, white counter, pipeline valids and latched enable all clear.
- Read rule: o_rd=1 when !i_almostempty && !obuf_almostfull && !i_flush && !flush_d1. At most one read per cycle.
- Pipeline:
  - S1 (o_rd+1): capture i_data, v1=1.
  - S2 (o_rd+2): compute lum = R+2G+B (6-bit unsigned, max 60); when enable_lat=1, out = (lum >= i_threshold) ? 12'hFFF : 12'h000; otherwise out = pixel unchanged. Write to obuf. Latency o_rd→obuf write = 2 cycles.
- Frame counter:
  - Increments on every S2 write; wraps from FRAME_PIXELS-1 to 0.
  - i_enable is latched into enable_lat only on the S2 write with counter==0, so the mode never changes mid-frame.
  - i_threshold is sampled the same way.
- White counter:
  - Increments on each S2 write with out==12'hFFF while enable_lat=1.
  - On the S2 write at counter==FRAME_PIXELS-1: o_white_count <= final count (including this pixel), white counter <= 0, o_eof=1 for that cycle.
- Output FIFO:
  - Synchronous, single clock, OBUF_DEPTH entries.
  - Simultaneous read and write: fill unchanged.
  - Read while empty: ignored; o_obuf_data holds its previous value.
  - Write while full cannot occur (OBUF_AF_MARGIN ≥ 2 in-flight words + 2). The bench asserts this.
- Flush (i_flush=1 for ≥1 cycle): in the same cycle, drop S1/S2 valids; clear FIFO pointers, fill, frame counter, white counter and enable_lat. o_white_count is retained. o_rd is held 0 during flush and for one cycle after. Words read from upstream before the flush are discarded.
- Reset mid-frame: same state as reset; no partial o_eof.

Decomposition:
- Shared package ps_pkg: PIX_W=12, FRAME_PIXELS, PIX_WHITE=12'hFFF, PIX_BLACK=12'h000, the luminance function, and the fill-width constant.
- One sub-module: ps_sync_fifo (parameterized depth, width, AE/AF thresholds, synchronous clear input for flush).

Test Plan:
- Bypass: i_enable=0, stream 8 pixels 12'h123..12'h12A → obuf holds identical 8 words in order; o_rd→write latency = 2 cycles; o_white_count=0 at eof.
- Threshold: i_enable=1, i_threshold=30, pixels 12'h777 (lum 28) and 12'h888 (lum 32) → 12'h000 and 12'hFFF respectively. Boundary pixel 12'h7F7 (lum 7+30+7=44) → 12'hFFF. Pixel with lum exactly 30 → 12'hFFF.
- Frame count: FRAME_PIXELS=16 override, 16 pixels with 5 above threshold → o_eof pulse on 16th write, o_white_count=5. Second frame counts from 0.
- Mid-frame enable toggle: raise i_enable at pixel 7 of 16 → whole current frame bypassed; next frame thresholded.
- Backpressure: never assert i_obuf_rd → o_rd stops with fill ≤ OBUF_DEPTH and no overflow. Drain 10 words → reads resume. Simultaneous rd/wr keeps fill constant.
- Flush: i_flush for 1 cycle mid-frame with 2 words in flight → fill=0, o_obuf_empty=1, no o_rd for 2 cycles, counter restarts. o_white_count keeps the prior frame's value.

Source files
------------

// File: rtl/ps_pkg.sv
// Shared constants and the luminance helper for the binary-threshold stage.
package ps_pkg;

  localparam int PIX_W        = 12;
  localparam int FRAME_PIXELS = 307200;
  localparam int CNT_W        = 19;
  localparam int OBUF_DEPTH   = 1024;
  localparam int OBUF_FILL_W  = $clog2(OBUF_DEPTH) + 1;

  localparam logic [PIX_W-1:0] PIX_WHITE = 12'hFFF;
  localparam logic [PIX_W-1:0] PIX_BLACK = 12'h000;

  // R + 2G + B on RGB444, always fits in 6 bits (max 60)
  function automatic logic [5:0] luminance(input logic [PIX_W-1:0] pix);
    return {2'b00, pix[11:8]} + {1'b0, pix[7:4], 1'b0} + {2'b00, pix[3:0]};
  endfunction

endpackage

// File: rtl/ps_sync_fifo.sv
// Single-clock FIFO with registered read data, fill count and a synchronous clear.
module ps_sync_fifo #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 1024,
  parameter int AE_THRESH = 16,
  parameter int AF_MARGIN = 4,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic             i_sysclk,
  input  logic             db_rstn,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   fill,
  output logic             empty,
  output logic             almostempty,
  output logic             almostfull
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr       = wr && !clr && (fill != (PTR_W+1)'(DEPTH));
  assign do_rd       = rd && !clr && (fill != '0);
  assign empty       = (fill == '0);
  assign almostempty = (fill <= (PTR_W+1)'(AE_THRESH));
  assign almostfull  = (fill >= (PTR_W+1)'(DEPTH - AF_MARGIN));

  always_ff @(posedge i_sysclk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      rdata  <= '0;
    end else if (clr) begin
      // read data register is left alone so the consumer sees a stable bus
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        rdata  <= mem[rd_ptr];
      end
      if (do_wr && !do_rd)      fill <= fill + (PTR_W+1)'(1);
      else if (!do_wr && do_rd) fill <= fill - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/ps_threshold_top.sv
// Binary-threshold stage: upstream FIFO -> 2-cycle luminance pipeline -> output FIFO,
// with per-frame white-pixel counting. Mode and threshold are frozen at each frame start.
module ps_threshold_top #(
  parameter int DATA_WIDTH     = ps_pkg::PIX_W,
  parameter int FRAME_PIXELS   = ps_pkg::FRAME_PIXELS,
  parameter int OBUF_DEPTH     = ps_pkg::OBUF_DEPTH,
  parameter int OBUF_AE_THRESH = 16,
  parameter int OBUF_AF_MARGIN = 4
) (
  input  logic                        i_sysclk,
  input  logic                        db_rstn,
  input  logic                        i_enable,
  input  logic [5:0]                  i_threshold,
  input  logic                        i_flush,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_almostempty,
  output logic                        o_rd,
  input  logic                        i_obuf_rd,
  output logic [DATA_WIDTH-1:0]       o_obuf_data,
  output logic [$clog2(OBUF_DEPTH):0] o_obuf_fill,
  output logic                        o_obuf_empty,
  output logic                        o_obuf_almostempty,
  output logic                        o_eof,
  output logic [18:0]                 o_white_count
);
  import ps_pkg::*;

  logic                  run;
  logic                  flush_d1;
  logic                  rd_d1;
  logic                  v1;
  logic [DATA_WIDTH-1:0] pix1;
  logic                  en_lat;
  logic [5:0]            thr_lat;
  logic [CNT_W-1:0]      pix_cnt;
  logic [CNT_W-1:0]      white_cnt;
  logic                  obuf_af;
  logic                  frame_start;
  logic                  frame_last;
  logic                  en_eff;
  logic [5:0]            thr_eff;
  logic                  is_white;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] pix_out;

  // run keeps o_rd low while reset is asserted
  assign o_rd        = run && !i_almostempty && !obuf_af && !i_flush && !flush_d1;
  assign wr_en       = v1 && !i_flush;
  assign frame_start = (pix_cnt == '0);
  assign frame_last  = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
  assign en_eff      = frame_start ? i_enable    : en_lat;
  assign thr_eff     = frame_start ? i_threshold : thr_lat;

  always_comb begin
    pix_out = pix1;
    if (en_eff) pix_out = (luminance(pix1) >= thr_eff) ? PIX_WHITE : PIX_BLACK;
  end

  assign is_white = en_eff && (pix_out == PIX_WHITE);

  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      run           <= 1'b0;
      flush_d1      <= 1'b0;
      rd_d1         <= 1'b0;
      v1            <= 1'b0;
      pix1          <= '0;
      en_lat        <= 1'b0;
      thr_lat       <= '0;
      pix_cnt       <= '0;
      white_cnt     <= '0;
      o_eof         <= 1'b0;
      o_white_count <= '0;
    end else begin
      run      <= 1'b1;
      flush_d1 <= i_flush;
      rd_d1    <= o_rd;
      v1       <= rd_d1 && !i_flush;
      o_eof    <= 1'b0;
      if (rd_d1) pix1 <= i_data;
      if (i_flush) begin
        pix_cnt   <= '0;
        white_cnt <= '0;
        en_lat    <= 1'b0;
        thr_lat   <= '0;
      end else if (wr_en) begin
        if (frame_start) begin
          en_lat  <= i_enable;
          thr_lat <= i_threshold;
        end
        if (frame_last) begin
          pix_cnt       <= '0;
          white_cnt     <= '0;
          o_white_count <= white_cnt + CNT_W'(is_white);
          o_eof         <= 1'b1;
        end else begin
          pix_cnt   <= pix_cnt + CNT_W'(1);
          white_cnt <= white_cnt + CNT_W'(is_white);
        end
      end
    end
  end

  ps_sync_fifo #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (OBUF_DEPTH),
    .AE_THRESH (OBUF_AE_THRESH),
    .AF_MARGIN (OBUF_AF_MARGIN)
  ) u_obuf (
    .i_sysclk    (i_sysclk),
    .db_rstn     (db_rstn),
    .clr         (i_flush),
    .wr          (wr_en),
    .wdata       (pix_out),
    .rd          (i_obuf_rd),
    .rdata       (o_obuf_data),
    .fill        (o_obuf_fill),
    .empty       (o_obuf_empty),
    .almostempty (o_obuf_almostempty),
    .almostfull  (obuf_af)
  );

endmodule

// File: tb/tb_ps_threshold_top.sv
// Scoreboard bench for ps_threshold_top with a 16-pixel frame.
module tb_ps_threshold_top;

  localparam int FP    = 16;
  localparam int DEPTH = 1024;
  localparam int AE    = 16;
  localparam int AFM   = 4;

  logic        i_sysclk = 1'b0;
  logic        db_rstn = 1'b0;
  logic        i_enable = 1'b0;
  logic [5:0]  i_threshold = 6'd0;
  logic        i_flush = 1'b0;
  logic [11:0] i_data = 12'h000;
  logic        i_almostempty = 1'b1;
  logic        o_rd;
  logic        i_obuf_rd = 1'b0;
  logic [11:0] o_obuf_data;
  logic [10:0] o_obuf_fill;
  logic        o_obuf_empty;
  logic        o_obuf_almostempty;
  logic        o_eof;
  logic [18:0] o_white_count;

  int n_checks = 0;
  int n_errors = 0;

  always #4 i_sysclk = ~i_sysclk;

  ps_threshold_top #(
    .DATA_WIDTH(12), .FRAME_PIXELS(FP), .OBUF_DEPTH(DEPTH),
    .OBUF_AE_THRESH(AE), .OBUF_AF_MARGIN(AFM)
  ) dut (
    .i_sysclk(i_sysclk), .db_rstn(db_rstn), .i_enable(i_enable),
    .i_threshold(i_threshold), .i_flush(i_flush), .i_data(i_data),
    .i_almostempty(i_almostempty), .o_rd(o_rd), .i_obuf_rd(i_obuf_rd),
    .o_obuf_data(o_obuf_data), .o_obuf_fill(o_obuf_fill),
    .o_obuf_empty(o_obuf_empty), .o_obuf_almostempty(o_obuf_almostempty),
    .o_eof(o_eof), .o_white_count(o_white_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // upstream source, pipeline shadow and expected output FIFO contents
  logic [11:0] src_q[$];
  logic [11:0] exp_q[$];
  logic        st1_v = 1'b0, st2_v = 1'b0;
  logic [11:0] st1_pix = '0, st2_pix = '0;
  int          m_cnt = 0, m_white = 0, m_fill = 0;
  logic        m_en_lat = 1'b0;
  logic [5:0]  m_thr_lat = '0;
  logic [18:0] m_white_reg = '0;
  logic        m_eof = 1'b0;
  logic [11:0] m_data = '0;
  logic        rd_pend = 1'b0;
  logic [11:0] rd_pend_val = '0;
  logic        m_flush_d1 = 1'b0;
  int          rd_seen = 0;
  int          eof_seen = 0;
  bit          model_on = 1'b0;

  function automatic int lum_ref(input logic [11:0] p);
    return int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0]);
  endfunction

  task automatic model_step();
    logic        exp_rd;
    logic        en_eff;
    logic [5:0]  thr_eff;
    logic [11:0] pout;
    if (rd_pend) begin
      m_data  = rd_pend_val;
      rd_pend = 1'b0;
    end
    check_val("obuf_data", o_obuf_data, m_data);
    check_val("fill", o_obuf_fill, m_fill);
    check_val("empty", o_obuf_empty, m_fill == 0);
    check_val("almostempty", o_obuf_almostempty, m_fill <= AE);
    check_val("no_overflow", o_obuf_fill <= DEPTH, 1);
    check_val("eof", o_eof, m_eof);
    check_val("white_count", o_white_count, m_white_reg);
    if (o_eof) eof_seen++;
    m_eof  = 1'b0;
    exp_rd = !i_almostempty && (m_fill < DEPTH - AFM) && !i_flush && !m_flush_d1;
    check_val("o_rd", o_rd, exp_rd);
    if (o_rd) rd_seen++;
    m_flush_d1 = i_flush;
    if (i_flush) begin
      st1_v = 1'b0; st2_v = 1'b0;
      exp_q.delete();
      m_fill = 0; m_cnt = 0; m_white = 0;
      m_en_lat = 1'b0; m_thr_lat = '0;
    end else begin
      if (i_obuf_rd && m_fill > 0) begin
        rd_pend = 1'b1;
        rd_pend_val = exp_q.pop_front();
        m_fill--;
      end
      if (st2_v) begin
        en_eff  = (m_cnt == 0) ? i_enable : m_en_lat;
        thr_eff = (m_cnt == 0) ? i_threshold : m_thr_lat;
        if (m_cnt == 0) begin
          m_en_lat  = i_enable;
          m_thr_lat = i_threshold;
        end
        if (!en_eff) pout = st2_pix;
        else pout = (lum_ref(st2_pix) >= int'(thr_eff)) ? 12'hFFF : 12'h000;
        if (en_eff && pout == 12'hFFF) m_white++;
        exp_q.push_back(pout);
        m_fill++;
        if (m_cnt == FP - 1) begin
          m_cnt = 0; m_white_reg = 19'(m_white); m_white = 0; m_eof = 1'b1;
        end else m_cnt++;
      end
      st2_v = st1_v; st2_pix = st1_pix;
    end
    st1_v = o_rd;
    if (o_rd) st1_pix = src_q.pop_front();
  endtask

  initial begin
    forever begin
      @(negedge i_sysclk);
      if (model_on) begin
        i_almostempty = (src_q.size() == 0);
        i_data = st1_v ? st1_pix : 12'($urandom);
        #1;
        model_step();
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(src_q.size() == 0 && !st1_v && !st2_v && (m_fill == 0 || !i_obuf_rd))
           && n < budget) begin
      @(negedge i_sysclk);
      n++;
    end
    if (n >= budget) check_val("idle_timeout", n, 0);
    repeat (3) @(negedge i_sysclk);
  endtask

  task automatic push_pix(input logic [11:0] p);
    src_q.push_back(p);
  endtask

  logic [11:0] thr_pix[16] = '{12'h777, 12'h888, 12'h7F7, 12'h787, 12'hFFF, 12'h0F0,
                               12'h000, 12'h111, 12'h222, 12'h333, 12'h444, 12'h555,
                               12'h666, 12'h700, 12'h007, 12'h070};
  logic [18:0] white_saved;
  int          rd0;

  initial begin
    i_almostempty = 1'b0;
    repeat (3) @(negedge i_sysclk);
    check_val("rst_o_rd", o_rd, 0);
    check_val("rst_data", o_obuf_data, 0);
    check_val("rst_fill", o_obuf_fill, 0);
    check_val("rst_empty", o_obuf_empty, 1);
    check_val("rst_ae", o_obuf_almostempty, 1);
    check_val("rst_eof", o_eof, 0);
    check_val("rst_white", o_white_count, 0);
    i_almostempty = 1'b1;
    db_rstn  = 1'b1;
    model_on = 1'b1;
    @(negedge i_sysclk);

    // bypass frame
    i_enable = 1'b0; i_threshold = 6'd30; i_obuf_rd = 1'b1;
    for (int k = 0; k < 8; k++) push_pix(12'h123 + 12'(k));
    wait_idle(200);
    for (int k = 0; k < 8; k++) push_pix(12'hFFF);
    wait_idle(200);
    check_val("bypass_eof_count", eof_seen, 1);
    check_val("bypass_white", o_white_count, 0);

    // thresholded frame with exactly five whites
    i_enable = 1'b1; i_threshold = 6'd30;
    for (int k = 0; k < 16; k++) push_pix(thr_pix[k]);
    wait_idle(200);
    check_val("thr_eof_count", eof_seen, 2);
    check_val("thr_white5", o_white_count, 5);

    // second frame counts from zero
    i_threshold = 6'd40;
    for (int k = 0; k < 16; k++) push_pix(12'($urandom));
    wait_idle(200);
    check_val("frame2_eof_count", eof_seen, 3);

    // enable raised mid-frame: this frame stays bypassed, next is thresholded
    i_enable = 1'b0;
    for (int k = 0; k < 7; k++) push_pix(12'hFFF);
    wait_idle(200);
    i_enable = 1'b1;
    for (int k = 0; k < 9; k++) push_pix(12'hFFF);
    wait_idle(200);
    check_val("toggle_bypassed", o_white_count, 0);
    for (int k = 0; k < 16; k++) push_pix(12'hFFF);
    wait_idle(200);
    check_val("toggle_next_thr", o_white_count, 16);

    // backpressure: output never read
    i_obuf_rd = 1'b0; i_threshold = 6'd20;
    for (int k = 0; k < 1040; k++) push_pix(12'($urandom));
    repeat (1100) @(negedge i_sysclk);
    check_val("bp_stalled", o_rd, 0);
    check_val("bp_fill_hi", o_obuf_fill >= DEPTH - AFM, 1);
    check_val("bp_src_left", src_q.size() > 0, 1);
    rd0 = rd_seen;
    i_obuf_rd = 1'b1;
    repeat (10) @(negedge i_sysclk);
    i_obuf_rd = 1'b0;
    repeat (5) @(negedge i_sysclk);
    check_val("bp_resume", rd_seen > rd0, 1);
    i_obuf_rd = 1'b1;
    repeat (30) @(negedge i_sysclk);

    // flush away the backlog, then drain what remains upstream
    white_saved = m_white_reg;
    i_flush = 1'b1;
    @(negedge i_sysclk);
    i_flush = 1'b0;
    wait_idle(400);
    check_val("flush1_white_kept", o_white_count, white_saved);

    // flush mid-frame with words in flight
    for (int k = 0; k < 40; k++) push_pix(12'($urandom));
    repeat (12) @(negedge i_sysclk);
    white_saved = m_white_reg;
    i_flush = 1'b1;
    @(negedge i_sysclk);
    i_flush = 1'b0;
    #2;
    check_val("flush_rd_low", o_rd, 0);
    check_val("flush_fill0", o_obuf_fill, 0);
    check_val("flush_empty", o_obuf_empty, 1);
    check_val("flush_white_kept", o_white_count, white_saved);
    wait_idle(400);

    // reads on an empty FIFO must leave the data bus alone
    repeat (5) @(negedge i_sysclk);
    i_obuf_rd = 1'b0;
    repeat (2) @(negedge i_sysclk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
